// File: rtl/unsat_index_scheduler.sv
// Shared reciprocal-table scheduler: arbitrates NUM_REQ requesters and returns
// rand mod m using a ceil(2^W/m) multiply followed by a single correction step.
module unsat_index_scheduler #(
    parameter int NUM_REQ       = 2,
    parameter int BUFFER_DEPTH  = 2048,
    parameter int M_TABLE_WIDTH = 32,
    parameter int RAND_WIDTH    = 16,
    localparam int ADDR_W       = $clog2(BUFFER_DEPTH)
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [NUM_REQ-1:0]             req_valid_i,
    output logic [NUM_REQ-1:0]             req_ready_o,
    input  logic [NUM_REQ*ADDR_W-1:0]      req_count_i,
    input  logic [NUM_REQ*RAND_WIDTH-1:0]  req_rand_i,
    output logic [NUM_REQ-1:0]             resp_valid_o,
    input  logic [NUM_REQ-1:0]             resp_ready_i,
    output logic [ADDR_W-1:0]              resp_index_o,
    output logic                           resp_err_o,
    output logic                           tbl_en_o,
    output logic [ADDR_W-1:0]              tbl_addr_o,
    input  logic [M_TABLE_WIDTH-1:0]       tbl_data_i
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int PW    = RAND_WIDTH + M_TABLE_WIDTH;
    localparam int RW    = RAND_WIDTH + ADDR_W + 2;

    typedef enum logic [2:0] {
        S_IDLE, S_GRANT, S_LOOKUP, S_WAIT, S_MUL, S_REM, S_DONE
    } state_t;

    state_t                  state;
    logic [PTR_W-1:0]        rr_ptr;
    logic [NUM_REQ-1:0]      gnt_oh;
    logic [ADDR_W-1:0]       m_q;
    logic [RAND_WIDTH-1:0]   rand_q;
    logic [RAND_WIDTH-1:0]   q_q;
    logic [M_TABLE_WIDTH-1:0] recip_q;

    logic [ADDR_W-1:0]       cnt_arr  [NUM_REQ];
    logic [RAND_WIDTH-1:0]   rand_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign cnt_arr[g]  = req_count_i[g*ADDR_W +: ADDR_W];
        assign rand_arr[g] = req_rand_i[g*RAND_WIDTH +: RAND_WIDTH];
    end

    // Round-robin search starting at rr_ptr, wrapping at NUM_REQ.
    logic             arb_found;
    logic [PTR_W-1:0] arb_idx;
    always_comb begin
        int unsigned idx;
        logic [PTR_W-1:0] sel;
        arb_found = 1'b0;
        arb_idx   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = i + int'(rr_ptr);
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            sel = PTR_W'(idx);
            if (!arb_found && req_valid_i[sel]) begin
                arb_found = 1'b1;
                arb_idx   = sel;
            end
        end
    end

    // Ceil reciprocal keeps r in [-m, 2m), so one signed correction suffices.
    logic [RW-1:0]     m_ext;
    logic [RW-1:0]     r_raw;
    logic [ADDR_W-1:0] r_idx;
    always_comb begin
        m_ext = RW'(m_q);
        r_raw = RW'(rand_q) - RW'(q_q) * m_ext;
        if (r_raw[RW-1])
            r_idx = ADDR_W'(r_raw + m_ext);
        else if (r_raw >= m_ext)
            r_idx = ADDR_W'(r_raw - m_ext);
        else
            r_idx = ADDR_W'(r_raw);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= S_IDLE;
            rr_ptr       <= '0;
            gnt_oh       <= '0;
            m_q          <= '0;
            rand_q       <= '0;
            q_q          <= '0;
            recip_q      <= '0;
            req_ready_o  <= '0;
            resp_valid_o <= '0;
            resp_index_o <= '0;
            resp_err_o   <= 1'b0;
            tbl_en_o     <= 1'b0;
            tbl_addr_o   <= '0;
        end else begin
            req_ready_o <= '0;
            case (state)
                S_IDLE: begin
                    if (arb_found) begin
                        req_ready_o <= NUM_REQ'(1) << arb_idx;
                        gnt_oh      <= NUM_REQ'(1) << arb_idx;
                        m_q         <= cnt_arr[arb_idx];
                        rand_q      <= rand_arr[arb_idx];
                        rr_ptr      <= (arb_idx == PTR_W'(NUM_REQ-1)) ? '0 : arb_idx + PTR_W'(1);
                        state       <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    if (m_q == '0) begin
                        resp_valid_o <= gnt_oh;
                        resp_err_o   <= 1'b1;
                        resp_index_o <= '0;
                        state        <= S_DONE;
                    end else begin
                        tbl_en_o   <= 1'b1;
                        tbl_addr_o <= m_q;
                        state      <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    tbl_en_o   <= 1'b0;
                    tbl_addr_o <= '0;
                    state      <= S_WAIT;
                end
                S_WAIT: begin
                    recip_q <= tbl_data_i;
                    state   <= S_MUL;
                end
                S_MUL: begin
                    q_q   <= RAND_WIDTH'((PW'(rand_q) * PW'(recip_q)) >> M_TABLE_WIDTH);
                    state <= S_REM;
                end
                S_REM: begin
                    resp_valid_o <= gnt_oh;
                    resp_index_o <= r_idx;
                    resp_err_o   <= 1'b0;
                    state        <= S_DONE;
                end
                S_DONE: begin
                    if ((resp_ready_i & gnt_oh) != '0) begin
                        resp_valid_o <= '0;
                        resp_index_o <= '0;
                        resp_err_o   <= 1'b0;
                        state        <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
